// File: rtl/idli_serial_regs_m.sv
// Slice-serial register file for the idli core: every register rotates one slice per
// run cycle, LS slice first; NUM_RD combinational read ports and one rotation-long write port.
module idli_serial_regs_m #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 16,
  parameter int SLICE_W  = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_R0  = 0,
  localparam int SLICES  = REG_W / SLICE_W,
  localparam int SEL_W   = $clog2(NUM_REGS),
  localparam int CNT_W   = (SLICES > 1) ? $clog2(SLICES) : 1
) (
  input  logic                             i_reg_gck,
  input  logic                             i_reg_rst,
  input  logic                             i_reg_run,
  input  logic [NUM_RD-1:0][SEL_W-1:0]     i_reg_rd_sel,
  output logic [NUM_RD-1:0][SLICE_W-1:0]   o_reg_rd_data,
  input  logic                             i_reg_wr_en,
  input  logic [SEL_W-1:0]                 i_reg_wr_sel,
  input  logic [SLICE_W-1:0]               i_reg_wr_data,
  output logic [CNT_W-1:0]                 o_reg_slice,
  output logic                             o_reg_wr_busy
);

  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(SLICES - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_act_q, wr_act_d;
  logic [SEL_W-1:0]   wr_sel_q, wr_sel_d;
  logic [REG_W-1:0]   regs_q [NUM_REGS];
  logic [REG_W-1:0]   regs_d [NUM_REGS];
  logic [SLICE_W-1:0] ins_slice [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;

  logic               at_first;
  logic               at_last;
  logic               wr_live;
  logic [SEL_W-1:0]   wr_tgt;

  // At slice 0 the request is taken straight from the inputs; afterwards the latched copy drives.
  always_comb begin
    at_first = (cnt_q == '0);
    at_last  = (cnt_q == LAST_SLICE);
    wr_live  = at_first ? i_reg_wr_en  : wr_act_q;
    wr_tgt   = at_first ? i_reg_wr_sel : wr_sel_q;

    cnt_d    = cnt_q;
    wr_act_d = wr_act_q;
    wr_sel_d = wr_sel_q;
    if (i_reg_run) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
      if (at_first) begin
        wr_act_d = i_reg_wr_en && !at_last;
        if (i_reg_wr_en) begin
          wr_sel_d = i_reg_wr_sel;
        end
      end else if (at_last) begin
        wr_act_d = 1'b0;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_hit[r]    = wr_live && (wr_tgt == SEL_W'(r)) && !((ZERO_R0 != 0) && (r == 0));
      ins_slice[r] = wr_hit[r] ? i_reg_wr_data : regs_q[r][SLICE_W-1:0];
      regs_d[r]    = regs_q[r];
      if (i_reg_run) begin
        regs_d[r] = (regs_q[r] >> SLICE_W) | (REG_W'(ins_slice[r]) << (REG_W - SLICE_W));
      end
    end
  end

  always_ff @(posedge i_reg_gck) begin
    if (i_reg_rst) begin
      cnt_q    <= '0;
      wr_act_q <= 1'b0;
      wr_sel_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      wr_act_q <= wr_act_d;
      wr_sel_q <= wr_sel_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // Reads see pre-edge state, so a register under write still shows its old slice.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      if ((ZERO_R0 != 0) && (i_reg_rd_sel[p] == '0)) begin
        o_reg_rd_data[p] = '0;
      end else begin
        o_reg_rd_data[p] = regs_q[i_reg_rd_sel[p]][SLICE_W-1:0];
      end
    end
  end

  assign o_reg_slice   = cnt_q;
  assign o_reg_wr_busy = wr_act_q;

endmodule

// File: tb/tb_idli_serial_regs_m.sv
// Bench for idli_serial_regs_m: a plain and a ZERO_R0 instance share all stimulus and are
// checked against a value-level register model plus directed vector tables.
module tb_idli_serial_regs_m;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, run, wen;
  logic [2:0]      wsel;
  logic [3:0]      wdata;
  logic [1:0][2:0] rsel;
  logic [1:0][3:0] rd0, rd1;
  logic [1:0]      sl0, sl1;
  logic            busy0, busy1;

  idli_serial_regs_m #(.NUM_REGS(8), .REG_W(16), .SLICE_W(4), .NUM_RD(2), .ZERO_R0(0)) dut0 (
    .i_reg_gck(clk), .i_reg_rst(rst), .i_reg_run(run), .i_reg_rd_sel(rsel),
    .o_reg_rd_data(rd0), .i_reg_wr_en(wen), .i_reg_wr_sel(wsel), .i_reg_wr_data(wdata),
    .o_reg_slice(sl0), .o_reg_wr_busy(busy0));

  idli_serial_regs_m #(.NUM_REGS(8), .REG_W(16), .SLICE_W(4), .NUM_RD(2), .ZERO_R0(1)) dut1 (
    .i_reg_gck(clk), .i_reg_rst(rst), .i_reg_run(run), .i_reg_rd_sel(rsel),
    .o_reg_rd_data(rd1), .i_reg_wr_en(wen), .i_reg_wr_sel(wsel), .i_reg_wr_data(wdata),
    .o_reg_slice(sl1), .o_reg_wr_busy(busy1));

  int tests = 0;
  int fails = 0;

  // Value-level model: committed register contents, a rotation position and one pending write.
  int unsigned mregs [8];
  int          mcnt;
  bit          mact;
  int          mtgt;
  int unsigned macc;
  bit          mvalid = 1'b0;

  int s_slice, s_slice_z, s_busy0, s_busy1;
  int s_rd0 [2];
  int s_rd1 [2];

  typedef struct {
    logic       run;
    logic       wen;
    logic [2:0] wsel;
    logic [3:0] wd;
    logic [2:0] s0;
    logic [2:0] s1;
    logic [1:0] es;
    logic       eb;
    logic [3:0] e0;
    logic [3:0] e1;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit ru, input bit we, input int ws, input int wd,
                      input int a, input int b);
    int sel [2];
    int exp;
    rst = r; run = ru; wen = we;
    wsel = 3'(ws); wdata = 4'(wd);
    rsel[0] = 3'(a); rsel[1] = 3'(b);
    sel[0] = a; sel[1] = b;
    #1;
    s_slice   = int'(sl0);
    s_slice_z = int'(sl1);
    s_busy0   = int'(busy0);
    s_busy1   = int'(busy1);
    for (int p = 0; p < 2; p++) begin
      s_rd0[p] = int'(rd0[p]);
      s_rd1[p] = int'(rd1[p]);
    end
    if (mvalid) begin
      chk("slice", s_slice, mcnt);
      chk("slice_z", s_slice_z, mcnt);
      chk("busy", s_busy0, int'(mact));
      chk("busy_z", s_busy1, int'(mact));
      for (int p = 0; p < 2; p++) begin
        exp = int'((mregs[sel[p]] >> (4 * mcnt)) & 32'hF);
        chk($sformatf("rd_p%0d_r%0d", p, sel[p]), s_rd0[p], exp);
        chk($sformatf("rdz_p%0d_r%0d", p, sel[p]), s_rd1[p], (sel[p] == 0) ? 0 : exp);
      end
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) mregs[i] = 0;
      mcnt = 0; mact = 1'b0; mtgt = 0; macc = 0; mvalid = 1'b1;
    end else if (ru && mvalid) begin
      if (mcnt == 0) begin
        mact = we; mtgt = ws; macc = int'(wd);
      end else if (mact) begin
        macc = macc | (int'(wd) << (4 * mcnt));
      end
      if (mcnt == 3 && mact) begin
        mregs[mtgt] = macc;
        mact = 1'b0;
      end
      mcnt = (mcnt + 1) % 4;
    end
    @(negedge clk);
  endtask

  initial begin
    // write r3=BEEF, read r3 during and after the write
    tbl[0]  = '{1'b1, 1'b1, 3'd3, 4'hF, 3'd3, 3'd3, 2'd0, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 3'd0, 4'hE, 3'd3, 3'd3, 2'd1, 1'b1, 4'h0, 4'h0};
    tbl[2]  = '{1'b1, 1'b0, 3'd0, 4'hE, 3'd3, 3'd3, 2'd2, 1'b1, 4'h0, 4'h0};
    tbl[3]  = '{1'b1, 1'b0, 3'd0, 4'hB, 3'd3, 3'd3, 2'd3, 1'b1, 4'h0, 4'h0};
    tbl[4]  = '{1'b1, 1'b0, 3'd0, 4'h0, 3'd3, 3'd3, 2'd0, 1'b0, 4'hF, 4'hF};
    tbl[5]  = '{1'b1, 1'b0, 3'd0, 4'h0, 3'd3, 3'd3, 2'd1, 1'b0, 4'hE, 4'hE};
    tbl[6]  = '{1'b1, 1'b0, 3'd0, 4'h0, 3'd3, 3'd3, 2'd2, 1'b0, 4'hE, 4'hE};
    tbl[7]  = '{1'b1, 1'b0, 3'd0, 4'h0, 3'd3, 3'd3, 2'd3, 1'b0, 4'hB, 4'hB};
    // r1=1234 then r2=ABCD back to back
    tbl[8]  = '{1'b1, 1'b1, 3'd1, 4'h4, 3'd1, 3'd2, 2'd0, 1'b0, 4'h0, 4'h0};
    tbl[9]  = '{1'b1, 1'b0, 3'd0, 4'h3, 3'd1, 3'd2, 2'd1, 1'b1, 4'h0, 4'h0};
    tbl[10] = '{1'b1, 1'b0, 3'd0, 4'h2, 3'd1, 3'd2, 2'd2, 1'b1, 4'h0, 4'h0};
    tbl[11] = '{1'b1, 1'b0, 3'd0, 4'h1, 3'd1, 3'd2, 2'd3, 1'b1, 4'h0, 4'h0};
    tbl[12] = '{1'b1, 1'b1, 3'd2, 4'hD, 3'd1, 3'd2, 2'd0, 1'b0, 4'h4, 4'h0};
    tbl[13] = '{1'b1, 1'b0, 3'd0, 4'hC, 3'd1, 3'd2, 2'd1, 1'b1, 4'h3, 4'h0};
    tbl[14] = '{1'b1, 1'b0, 3'd0, 4'hB, 3'd1, 3'd2, 2'd2, 1'b1, 4'h2, 4'h0};
    tbl[15] = '{1'b1, 1'b0, 3'd0, 4'hA, 3'd1, 3'd2, 2'd3, 1'b1, 4'h1, 4'h0};
    // dual read, plus a late request for r5 at slices 2 and 3
    tbl[16] = '{1'b1, 1'b0, 3'd0, 4'h0, 3'd1, 3'd2, 2'd0, 1'b0, 4'h4, 4'hD};
    tbl[17] = '{1'b1, 1'b0, 3'd0, 4'h0, 3'd1, 3'd2, 2'd1, 1'b0, 4'h3, 4'hC};
    tbl[18] = '{1'b1, 1'b1, 3'd5, 4'h7, 3'd1, 3'd2, 2'd2, 1'b0, 4'h2, 4'hB};
    tbl[19] = '{1'b1, 1'b1, 3'd5, 4'h7, 3'd1, 3'd2, 2'd3, 1'b0, 4'h1, 4'hA};
    tbl[20] = '{1'b1, 1'b0, 3'd0, 4'h0, 3'd5, 3'd5, 2'd0, 1'b0, 4'h0, 4'h0};
    tbl[21] = '{1'b1, 1'b0, 3'd0, 4'h0, 3'd5, 3'd5, 2'd1, 1'b0, 4'h0, 4'h0};
    tbl[22] = '{1'b1, 1'b0, 3'd0, 4'h0, 3'd5, 3'd5, 2'd2, 1'b0, 4'h0, 4'h0};
    tbl[23] = '{1'b1, 1'b0, 3'd0, 4'h0, 3'd5, 3'd5, 2'd3, 1'b0, 4'h0, 4'h0};

    rst = 1'b1; run = 1'b0; wen = 1'b0; wsel = '0; wdata = '0; rsel = '0;
    @(negedge clk);

    // reset for two cycles, then four run cycles and a held cycle
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, k < 4, 1'b0, 0, 0, k % 8, (k + 4) % 8);
      chk("rst_slice", s_slice, k % 4);
      chk("rst_busy", s_busy0, 0);
      chk("rst_rd0", s_rd0[0], 0);
      chk("rst_rd1", s_rd0[1], 0);
    end

    for (int i = 0; i < 24; i++) begin
      step(1'b0, tbl[i].run, tbl[i].wen, int'(tbl[i].wsel), int'(tbl[i].wd),
           int'(tbl[i].s0), int'(tbl[i].s1));
      chk($sformatf("tbl%0d_slice", i), s_slice, int'(tbl[i].es));
      chk($sformatf("tbl%0d_busy", i), s_busy0, int'(tbl[i].eb));
      chk($sformatf("tbl%0d_busyz", i), s_busy1, int'(tbl[i].eb));
      chk($sformatf("tbl%0d_rd0", i), s_rd0[0], int'(tbl[i].e0));
      chk($sformatf("tbl%0d_rd1", i), s_rd0[1], int'(tbl[i].e1));
      chk($sformatf("tbl%0d_rdz0", i), s_rd1[0], int'(tbl[i].e0));
      chk($sformatf("tbl%0d_rdz1", i), s_rd1[1], int'(tbl[i].e1));
    end

    // stall three cycles after slice 1 of a write of r6=5A5A
    step(1'b0, 1'b1, 1'b1, 6, 'hA, 6, 6);
    step(1'b0, 1'b1, 1'b0, 0, 'h5, 6, 6);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 6, 'hF, 6, 6);
      chk("stall_slice", s_slice, 2);
      chk("stall_busy", s_busy0, 1);
    end
    step(1'b0, 1'b1, 1'b0, 0, 'hA, 6, 6);
    step(1'b0, 1'b1, 1'b0, 0, 'h5, 6, 6);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 0, 0, 6, 6);
      chk("stall_rd", s_rd0[0], (k % 2 == 1) ? 'h5 : 'hA);
    end

    // write r0=FFFF: the ZERO_R0 instance stays 0 but still reports busy
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, k == 0, 0, 'hF, 0, 0);
      chk("z_busy", s_busy1, (k == 0) ? 0 : 1);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
      chk("z_rd", s_rd1[0], 0);
      chk("nz_rd", s_rd0[0], 'hF);
    end

    // reset at slice 2 of a write of r4=9999
    step(1'b0, 1'b1, 1'b1, 4, 9, 4, 4);
    step(1'b0, 1'b1, 1'b0, 0, 9, 4, 4);
    step(1'b1, 1'b1, 1'b0, 0, 9, 4, 4);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 0, 0, 4, 3);
      if (k == 0) begin
        chk("rstw_slice", s_slice, 0);
        chk("rstw_busy", s_busy0, 0);
      end
      chk("rstw_r4", s_rd0[0], 0);
      chk("rstw_r3", s_rd0[1], 0);
    end

    // consecutive-rotation writes of r2
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, k == 0, 2, 1, 2, 2);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, k == 0, 2, 2, 2, 2);
      chk("b2b_old", s_rd0[0], 1);
      chk("b2b_busy", s_busy0, (k == 0) ? 0 : 1);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 0, 0, 2, 2);
      chk("b2b_new", s_rd0[0], 2);
    end

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(63) == 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
           int'($urandom_range(7)), int'($urandom_range(15)),
           int'($urandom_range(7)), int'($urandom_range(7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
